fsm_upload_flit: RTL and testbench

- Transmit-side counterpart of the IN_local download path.
- Takes one complete message from the cache/home controller as up to 11 parallel 16-bit flits and loads it in one cycle.
- Serializes the message as 18-bit flits ({ctrl[1:0], flit[15:0]}) into either the OUT_local request FIFO or the OUT_local reply FIFO.
- Stalls whenever the selected FIFO is full.

---
 rtl/flit_pkg.sv | 37 +++
 rtl/upload_flit_rf.sv | 34 +++
 rtl/fsm_upload_flit.sv | 127 ++++++++++++
 tb/tb_fsm_upload_flit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_pkg.sv
// Shared flit definitions for the OUT_local upload path.
// Covers widths, message lengths, ctrl encodings and the upload state encoding.
package flit_pkg;

  localparam int FLIT_W    = 16;
  localparam int CTRL_W    = 2;
  localparam int CNT_W     = 4;
  localparam int SHORT_LEN = 3;
  localparam int LONG_LEN  = 11;

  localparam logic [CNT_W-1:0] SHORT_LEN_C = 4'd3;
  localparam logic [CNT_W-1:0] LONG_LEN_C  = 4'd11;

  localparam logic [CTRL_W-1:0] CTRL_HEAD = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_BODY = 2'b10;
  localparam logic [CTRL_W-1:0] CTRL_TAIL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } upload_state_t;

  // Head wins over tail so a degenerate length-1 message would still carry a head marker.
  function automatic logic [CTRL_W-1:0] flit_ctrl(input logic [CNT_W-1:0] idx,
                                                  input logic [CNT_W-1:0] len);
    logic [CTRL_W-1:0] ctrl;
    if (idx == 4'd0) begin
      ctrl = CTRL_HEAD;
    end else if (idx == (len - 4'd1)) begin
      ctrl = CTRL_TAIL;
    end else begin
      ctrl = CTRL_BODY;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/upload_flit_rf.sv
// 11x16 flit register file: all entries load together, one entry is read by index.
module upload_flit_rf
  import flit_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [LONG_LEN-1:0][FLIT_W-1:0]  wr_data,
  input  logic [CNT_W-1:0]                 rd_idx,
  output logic [FLIT_W-1:0]                rd_data
);

  logic [LONG_LEN-1:0][FLIT_W-1:0] regs_r;

  // Capture the whole message in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_r <= '0;
    end else if (load) begin
      regs_r <= wr_data;
    end
  end

  // Indices past the last entry read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_idx < LONG_LEN_C) begin
      rd_data = regs_r[rd_idx];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/fsm_upload_flit.sv
// Upload FSM: captures a 3- or 11-flit message and serializes it as {ctrl, flit}
// into the OUT_local request or reply FIFO, stalling while the selected FIFO is full.
module fsm_upload_flit
  import flit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     msg_valid,
  input  logic                     msg_is_rep,
  input  logic                     msg_long,
  input  logic [FLIT_W-1:0]        head_flit,
  input  logic [FLIT_W-1:0]        addrHI_flit,
  input  logic [FLIT_W-1:0]        addrLO_flit,
  input  logic [FLIT_W-1:0]        data1HI_flit,
  input  logic [FLIT_W-1:0]        data1LO_flit,
  input  logic [FLIT_W-1:0]        data2HI_flit,
  input  logic [FLIT_W-1:0]        data2LO_flit,
  input  logic [FLIT_W-1:0]        data3HI_flit,
  input  logic [FLIT_W-1:0]        data3LO_flit,
  input  logic [FLIT_W-1:0]        data4HI_flit,
  input  logic [FLIT_W-1:0]        data4LO_flit,
  output logic                     msg_ack,
  output logic                     upload_busy,
  output logic                     upload_done,
  input  logic                     req_fifo_full,
  input  logic                     rep_fifo_full,
  output logic                     en_push_req,
  output logic                     en_push_rep,
  output logic [CTRL_W+FLIT_W-1:0] out_flit
);

  upload_state_t                   state_r;
  logic [CNT_W-1:0]                cnt_r;
  logic [CNT_W-1:0]                len_r;
  logic                            sel_rep_r;
  logic                            upload_done_r;

  logic                            load_s;
  logic                            sel_full_s;
  logic [FLIT_W-1:0]               rd_flit_s;
  logic [LONG_LEN-1:0][FLIT_W-1:0] flit_bus_s;

  // Entry 0 is the head flit, entry 10 the last data flit.
  assign flit_bus_s = {data4LO_flit, data4HI_flit, data3LO_flit, data3HI_flit,
                       data2LO_flit, data2HI_flit, data1LO_flit, data1HI_flit,
                       addrLO_flit, addrHI_flit, head_flit};

  assign load_s     = (state_r == ST_IDLE) && msg_valid;
  assign sel_full_s = sel_rep_r ? rep_fifo_full : req_fifo_full;

  upload_flit_rf u_rf (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .wr_data (flit_bus_s),
    .rd_idx  (cnt_r),
    .rd_data (rd_flit_s)
  );

  // State, flit counter, target selection and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      len_r         <= SHORT_LEN_C;
      sel_rep_r     <= 1'b0;
      upload_done_r <= 1'b0;
    end else begin
      upload_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (msg_valid) begin
            sel_rep_r <= msg_is_rep;
            len_r     <= msg_long ? LONG_LEN_C : SHORT_LEN_C;
            cnt_r     <= 4'd0;
            state_r   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!sel_full_s) begin
            if (cnt_r == (len_r - 4'd1)) begin
              state_r       <= ST_IDLE;
              cnt_r         <= 4'd0;
              upload_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign upload_done = upload_done_r;

  // Push and flit mux follow the selected FIFO's full flag within the same cycle.
  always_comb begin
    msg_ack     = 1'b0;
    upload_busy = 1'b0;
    en_push_req = 1'b0;
    en_push_rep = 1'b0;
    out_flit    = '0;
    case (state_r)
      ST_IDLE: begin
        msg_ack = msg_valid;
      end
      ST_SEND: begin
        upload_busy = 1'b1;
        if (!sel_full_s) begin
          en_push_rep = sel_rep_r;
          en_push_req = !sel_rep_r;
          out_flit    = {flit_ctrl(cnt_r, len_r), rd_flit_s};
        end else begin
          out_flit = '0;
        end
      end
      default: begin
        msg_ack = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_upload_flit.sv
// Directed self-checking bench for fsm_upload_flit.
module tb_fsm_upload_flit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_is_rep = 1'b0;
  logic        msg_long = 1'b0;
  logic [15:0] fl [11];
  logic        msg_ack, upload_busy, upload_done;
  logic        req_fifo_full = 1'b0;
  logic        rep_fifo_full = 1'b0;
  logic        en_push_req, en_push_rep;
  logic [17:0] out_flit;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_upload_flit dut (
    .clk           (clk),
    .rst           (rst),
    .msg_valid     (msg_valid),
    .msg_is_rep    (msg_is_rep),
    .msg_long      (msg_long),
    .head_flit     (fl[0]),
    .addrHI_flit   (fl[1]),
    .addrLO_flit   (fl[2]),
    .data1HI_flit  (fl[3]),
    .data1LO_flit  (fl[4]),
    .data2HI_flit  (fl[5]),
    .data2LO_flit  (fl[6]),
    .data3HI_flit  (fl[7]),
    .data3LO_flit  (fl[8]),
    .data4HI_flit  (fl[9]),
    .data4LO_flit  (fl[10]),
    .msg_ack       (msg_ack),
    .upload_busy   (upload_busy),
    .upload_done   (upload_done),
    .req_fifo_full (req_fifo_full),
    .rep_fifo_full (rep_fifo_full),
    .en_push_req   (en_push_req),
    .en_push_rep   (en_push_rep),
    .out_flit      (out_flit)
  );

  // Expected ctrl for flit i of an 11-flit message.
  function automatic logic [17:0] long_exp(input int i, input logic [15:0] base);
    logic [1:0] c;
    c = (i == 0) ? 2'b01 : ((i == 10) ? 2'b11 : 2'b10);
    return {c, base + 16'(i)};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    msg_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({msg_ack, upload_busy, upload_done, en_push_req, en_push_rep} !== 5'b0 || out_flit !== 18'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b busy=%b done=%b req=%b rep=%b flit=%h, want all 0",
               msg_ack, upload_busy, upload_done, en_push_req, en_push_rep, out_flit);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (upload_busy !== 1'b0 || en_push_req !== 1'b0 || en_push_rep !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: got busy=%b req=%b rep=%b, want 0 0 0", upload_busy, en_push_req, en_push_rep);
    end
  endtask

  task automatic test_short_req();
    logic [17:0] exp [3];
    exp[0] = 18'h12001; exp[1] = 18'h2ABCD; exp[2] = 18'h31234;
    @(posedge clk); #1;
    fl[0] = 16'h2001; fl[1] = 16'hABCD; fl[2] = 16'h1234;
    for (int i = 3; i < 11; i++) fl[i] = 16'hFFFF;
    msg_is_rep = 1'b0; msg_long = 1'b0; msg_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (msg_ack !== 1'b1 || upload_busy !== 1'b0) begin
      fails++;
      $display("FAIL short_ack: got ack=%b busy=%b, want 1 0", msg_ack, upload_busy);
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (en_push_req !== 1'b1 || en_push_rep !== 1'b0 || out_flit !== exp[i] || msg_ack !== 1'b0 || upload_busy !== 1'b1) begin
        fails++;
        $display("FAIL short_push%0d: got req=%b rep=%b flit=%h ack=%b busy=%b, want 1 0 %h 0 1",
                 i, en_push_req, en_push_rep, out_flit, msg_ack, upload_busy, exp[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (upload_done !== 1'b1 || upload_busy !== 1'b0 || en_push_req !== 1'b0 || en_push_rep !== 1'b0) begin
      fails++;
      $display("FAIL short_done: got done=%b busy=%b req=%b rep=%b, want 1 0 0 0", upload_done, upload_busy, en_push_req, en_push_rep);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (upload_done !== 1'b0) begin
      fails++;
      $display("FAIL short_done_pulse: got done=%b, want 0", upload_done);
    end
  endtask

  task automatic test_long_rep();
    int pcount = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) fl[i] = 16'(i);
    msg_is_rep = 1'b1; msg_long = 1'b1; msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    for (int c = 0; c < 40 && pcount < 11; c++) begin
      @(negedge clk);
      if (en_push_req !== 1'b0) begin
        tests++; fails++;
        $display("FAIL long_wrong_fifo: got en_push_req=%b, want 0", en_push_req);
      end
      if (en_push_rep === 1'b1) begin
        tests++;
        if (out_flit !== long_exp(pcount, 16'h0000)) begin
          fails++;
          $display("FAIL long_flit%0d: got %h, want %h", pcount, out_flit, long_exp(pcount, 16'h0000));
        end
        pcount++;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (pcount != 11) begin
      fails++;
      $display("FAIL long_push_count: got %0d, want 11", pcount);
    end
    @(negedge clk);
    tests++;
    if (upload_done !== 1'b1 || upload_busy !== 1'b0) begin
      fails++;
      $display("FAIL long_done: got done=%b busy=%b, want 1 0", upload_done, upload_busy);
    end
  endtask

  task automatic test_backpressure();
    int pcount = 0;
    int stalls = 0;
    int stall_seen = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) fl[i] = 16'(i);
    msg_is_rep = 1'b1; msg_long = 1'b1; msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    for (int c = 0; c < 40 && pcount < 11; c++) begin
      if (pcount == 4 && stalls < 3) begin
        rep_fifo_full = 1'b1;
        stalls++;
      end else begin
        rep_fifo_full = 1'b0;
      end
      req_fifo_full = ~req_fifo_full;
      @(negedge clk);
      if (rep_fifo_full) begin
        stall_seen++;
        tests++;
        if (en_push_rep !== 1'b0 || en_push_req !== 1'b0 || out_flit !== 18'h0) begin
          fails++;
          $display("FAIL bp_stall: got req=%b rep=%b flit=%h, want 0 0 0", en_push_req, en_push_rep, out_flit);
        end
      end else begin
        if (en_push_req !== 1'b0) begin
          tests++; fails++;
          $display("FAIL bp_wrong_fifo: got en_push_req=%b, want 0", en_push_req);
        end
        if (en_push_rep === 1'b1) begin
          tests++;
          if (out_flit !== long_exp(pcount, 16'h0000)) begin
            fails++;
            $display("FAIL bp_flit%0d: got %h, want %h", pcount, out_flit, long_exp(pcount, 16'h0000));
          end
          pcount++;
        end
      end
      @(posedge clk); #1;
    end
    rep_fifo_full = 1'b0;
    req_fifo_full = 1'b0;
    tests++;
    if (pcount != 11 || stall_seen != 3) begin
      fails++;
      $display("FAIL bp_counts: got pushes=%0d stalls=%0d, want 11 3", pcount, stall_seen);
    end
    @(negedge clk);
    tests++;
    if (upload_done !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: got done=%b, want 1", upload_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_ack;
    logic [17:0] exp_flit [8];
    logic [7:0]  exp_req;
    logic [7:0]  exp_rep;
    exp_ack = 8'b0001_0001;
    exp_req = 8'b0000_1110;
    exp_rep = 8'b1110_0000;
    exp_flit[0] = 18'h0; exp_flit[4] = 18'h0;
    exp_flit[1] = 18'h12101; exp_flit[2] = 18'h25555; exp_flit[3] = 18'h3AAAA;
    exp_flit[5] = 18'h12202; exp_flit[6] = 18'h20F0F; exp_flit[7] = 18'h3F0F0;
    @(posedge clk); #1;
    fl[0] = 16'h2101; fl[1] = 16'h5555; fl[2] = 16'hAAAA;
    msg_is_rep = 1'b0; msg_long = 1'b0; msg_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (msg_ack !== exp_ack[c] || en_push_req !== exp_req[c] || en_push_rep !== exp_rep[c] || out_flit !== exp_flit[c]) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got ack=%b req=%b rep=%b flit=%h, want %b %b %b %h",
                 c, msg_ack, en_push_req, en_push_rep, out_flit, exp_ack[c], exp_req[c], exp_rep[c], exp_flit[c]);
      end
      if (c == 4) begin
        tests++;
        if (upload_done !== 1'b1) begin
          fails++;
          $display("FAIL b2b_done: got done=%b, want 1", upload_done);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        fl[0] = 16'h2202; fl[1] = 16'h0F0F; fl[2] = 16'hF0F0;
        msg_is_rep = 1'b1;
      end
      if (c == 4) msg_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (upload_done !== 1'b1 || upload_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done2: got done=%b busy=%b, want 1 0", upload_done, upload_busy);
    end
  endtask

  task automatic test_reset_mid();
    int pcount = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) fl[i] = 16'h1000 + 16'(i);
    msg_is_rep = 1'b0; msg_long = 1'b1; msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (en_push_req === 1'b1) pcount++;
      if (pcount == 5) break;
      @(posedge clk); #1;
    end
    tests++;
    if (pcount != 5) begin
      fails++;
      $display("FAIL rstmid_prefix: got %0d pushes, want 5", pcount);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (en_push_req !== 1'b0 || en_push_rep !== 1'b0 || upload_busy !== 1'b0 || upload_done !== 1'b0 || out_flit !== 18'h0) begin
      fails++;
      $display("FAIL rstmid_quiet: got req=%b rep=%b busy=%b done=%b flit=%h, want 0 0 0 0 0",
               en_push_req, en_push_rep, upload_busy, upload_done, out_flit);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    fl[0] = 16'h3003; fl[1] = 16'h0001; fl[2] = 16'h0002;
    msg_long = 1'b0; msg_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (msg_ack !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_ack: got ack=%b, want 1", msg_ack);
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (en_push_req !== 1'b1 || out_flit !== 18'h13003) begin
      fails++;
      $display("FAIL rstmid_head: got req=%b flit=%h, want 1 13003", en_push_req, out_flit);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 11; i++) fl[i] = 16'h0;
    test_reset();
    test_short_req();
    test_long_rep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
